// File: rtl/morse_match_engine_if.sv
// Bundles the key/tick/commit inputs and the game status outputs of the morse match engine.
// The master side drives keys and pulses, and the engine sits on the slave side.
interface morse_match_engine_if #(
  parameter int SYM_W  = 10,
  parameter int ADDR_W = 4
);
  logic              tick;
  logic              key;
  logic              next;
  logic              done;
  logic [1:0]        state;
  logic [SYM_W-1:0]  sym_live;
  logic [ADDR_W:0]   rec_len;
  logic [ADDR_W:0]   guess_idx;
  logic              last_valid;
  logic              last_match;
  logic [ADDR_W:0]   score;
  logic              win;
  logic              mem_full;

  modport master (
    output tick, key, next, done,
    input  state, sym_live, rec_len, guess_idx, last_valid, last_match, score, win, mem_full
  );

  modport slave (
    input  tick, key, next, done,
    output state, sym_live, rec_len, guess_idx, last_valid, last_match, score, win, mem_full
  );
endinterface

// File: rtl/morse_match_engine.sv
// Record/guess engine for the spy morse game: player 1 records up to DEPTH symbols,
// player 2 keys guesses that are scored symbol-by-symbol against the stored message.
module morse_match_engine #(
  parameter int SYM_W  = 10,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  morse_match_engine_if.slave  bus
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_REC    = 2'd1,
    ST_GUESS  = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  state_t             r_state;
  logic [SYM_W-1:0]   r_sym;
  logic [ADDR_W:0]    r_rec_len;
  logic [ADDR_W:0]    r_guess_idx;
  logic [ADDR_W:0]    r_score;
  logic               r_last_valid;
  logic               r_last_match;
  logic [SYM_W-1:0]   r_mem [DEPTH];

  logic               w_full;
  logic               w_rec_wr;
  logic               w_guess_end;
  logic               w_match;
  logic [SYM_W-1:0]   w_shifted;
  logic [SYM_W-1:0]   w_guess_sym;

  assign w_full      = (r_rec_len == DEPTH_C);
  assign w_shifted   = {r_sym[SYM_W-2:0], bus.key};
  // done in the same cycle always drops next, even when done itself is ignored
  assign w_rec_wr    = (r_state == ST_REC) && bus.next && !bus.done && !w_full;
  assign w_guess_end = (r_guess_idx == r_rec_len);
  assign w_guess_sym = r_mem[r_guess_idx[ADDR_W-1:0]];
  assign w_match     = (r_sym == w_guess_sym);

  // Message storage: contents are never reset and survive across rounds.
  always_ff @(posedge i_clock) begin
    if (w_rec_wr) begin
      r_mem[r_rec_len[ADDR_W-1:0]] <= r_sym;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= ST_START;
      r_sym        <= '0;
      r_rec_len    <= '0;
      r_guess_idx  <= '0;
      r_score      <= '0;
      r_last_valid <= 1'b0;
      r_last_match <= 1'b0;
    end else begin
      case (r_state)
        ST_START: begin
          if (bus.done) begin
            r_state      <= ST_REC;
            r_sym        <= '0;
            r_rec_len    <= '0;
            r_guess_idx  <= '0;
            r_score      <= '0;
            r_last_valid <= 1'b0;
            r_last_match <= 1'b0;
          end else if (bus.tick) begin
            r_sym <= w_shifted;
          end
        end

        ST_REC: begin
          if (bus.done && (r_rec_len != '0)) begin
            r_state <= ST_GUESS;
            r_sym   <= '0;
          end else if (w_rec_wr) begin
            // a tick in the commit cycle is discarded: the pre-shift symbol is stored
            r_rec_len <= r_rec_len + ONE_C;
            r_sym     <= '0;
          end else if (bus.tick) begin
            r_sym <= w_shifted;
          end
        end

        ST_GUESS: begin
          if (bus.done || w_guess_end) begin
            r_state <= ST_RESULT;
            r_sym   <= '0;
          end else if (bus.next) begin
            r_last_match <= w_match;
            r_last_valid <= 1'b1;
            r_score      <= r_score + {{ADDR_W{1'b0}}, w_match};
            r_guess_idx  <= r_guess_idx + ONE_C;
            r_sym        <= '0;
          end else if (bus.tick) begin
            r_sym <= w_shifted;
          end
        end

        default: begin
          if (bus.done) begin
            // leaving RESULT presents a clean scoreboard in START
            r_state      <= ST_START;
            r_sym        <= '0;
            r_rec_len    <= '0;
            r_guess_idx  <= '0;
            r_score      <= '0;
            r_last_valid <= 1'b0;
            r_last_match <= 1'b0;
          end else if (bus.tick) begin
            r_sym <= w_shifted;
          end
        end
      endcase
    end
  end

  assign bus.state      = r_state;
  assign bus.sym_live   = r_sym;
  assign bus.rec_len    = r_rec_len;
  assign bus.guess_idx  = r_guess_idx;
  assign bus.score      = r_score;
  assign bus.last_valid = r_last_valid;
  assign bus.last_match = r_last_match;
  assign bus.win        = (r_state == ST_RESULT) && (r_score == r_rec_len);
  assign bus.mem_full   = w_full;

endmodule

// File: tb/tb_morse_match_engine.sv
// Bench for morse_match_engine: a DEPTH=16 instance driven from a vector table and a
// DEPTH=4 instance exercised for the full-memory boundary, both checked through a scoreboard.
module tb_morse_match_engine;

  localparam int OP_KEY   = 0;
  localparam int OP_NEXT  = 1;
  localparam int OP_DONE  = 2;
  localparam int OP_IDLE  = 3;
  localparam int OP_TNEXT = 4;
  localparam int OP_DNEXT = 5;
  localparam int OP_RST   = 6;

  typedef struct {
    int st;
    int sym;
    int rl;
    int gi;
    int sc;
    int lv;
    int lm;
    int win;
    int full;
  } exp_t;

  typedef struct {
    int   op;
    int   sym;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_s = 1'b0;
  logic tick_s = 1'b0;
  logic key_s = 1'b0;
  logic next_s = 1'b0;
  logic done_s = 1'b0;

  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb_q[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  morse_match_engine_if #(.SYM_W(10), .ADDR_W(4)) ifa ();
  morse_match_engine_if #(.SYM_W(10), .ADDR_W(2)) ifb ();

  assign ifa.tick = tick_s;
  assign ifa.key  = key_s;
  assign ifa.next = next_s;
  assign ifa.done = done_s;
  assign ifb.tick = tick_s;
  assign ifb.key  = key_s;
  assign ifb.next = next_s;
  assign ifb.done = done_s;

  morse_match_engine #(.SYM_W(10), .DEPTH(16), .ADDR_W(4)) dut_a (
    .i_clock (clk),
    .i_reset (rst_s),
    .bus     (ifa)
  );

  morse_match_engine #(.SYM_W(10), .DEPTH(4), .ADDR_W(2)) dut_b (
    .i_clock (clk),
    .i_reset (rst_s),
    .bus     (ifb)
  );

  function automatic exp_t mk(int st, int sym, int rl, int gi, int sc,
                              int lv, int lm, int win, int full);
    exp_t e;
    e.st = st; e.sym = sym; e.rl = rl; e.gi = gi; e.sc = sc;
    e.lv = lv; e.lm = lm; e.win = win; e.full = full;
    return e;
  endfunction

  function automatic exp_t observe(int sel);
    exp_t o;
    if (sel == 0) begin
      o = mk(int'(ifa.state), int'(ifa.sym_live), int'(ifa.rec_len), int'(ifa.guess_idx),
             int'(ifa.score), int'(ifa.last_valid), int'(ifa.last_match),
             int'(ifa.win), int'(ifa.mem_full));
    end else begin
      o = mk(int'(ifb.state), int'(ifb.sym_live), int'(ifb.rec_len), int'(ifb.guess_idx),
             int'(ifb.score), int'(ifb.last_valid), int'(ifb.last_match),
             int'(ifb.win), int'(ifb.mem_full));
    end
    return o;
  endfunction

  task automatic add(int op, int sym, exp_t e);
    vec_t v;
    v.op = op; v.sym = sym; v.e = e;
    vecs.push_back(v);
  endtask

  task automatic drive(logic r, logic t, logic k, logic n, logic d);
    @(negedge clk);
    rst_s = r; tick_s = t; key_s = k; next_s = n; done_s = d;
    @(posedge clk);
    #1;
    rst_s = 1'b0; tick_s = 1'b0; key_s = 1'b0; next_s = 1'b0; done_s = 1'b0;
  endtask

  task automatic apply_op(int op, int sym);
    logic [3:0] bits;
    bits = 4'(sym);
    case (op)
      OP_KEY:   for (int i = 3; i >= 0; i--) drive(1'b0, 1'b1, bits[i], 1'b0, 1'b0);
      OP_NEXT:  drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      OP_DONE:  drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      OP_TNEXT: drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      OP_DNEXT: drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      OP_RST:   drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      default:  drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endcase
  endtask

  task automatic cmp(string tag, string f, int act, int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s %s: got %0d expected %0d", tag, f, act, req);
  endtask

  task automatic check_sb(string tag, int sel);
    exp_t e;
    exp_t o;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
      return;
    end
    e = sb_q.pop_front();
    o = observe(sel);
    cmp(tag, "state", o.st, e.st);
    cmp(tag, "sym_live", o.sym, e.sym);
    cmp(tag, "rec_len", o.rl, e.rl);
    cmp(tag, "guess_idx", o.gi, e.gi);
    cmp(tag, "score", o.sc, e.sc);
    cmp(tag, "last_valid", o.lv, e.lv);
    cmp(tag, "last_match", o.lm, e.lm);
    cmp(tag, "win", o.win, e.win);
    cmp(tag, "mem_full", o.full, e.full);
    $display("tx %s: state=%0d sym=%0d rec_len=%0d guess_idx=%0d score=%0d win=%0d full=%0d",
             tag, o.st, o.sym, o.rl, o.gi, o.sc, o.win, o.full);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t z;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // round 1: record 7,1,5 then guess 7,2,5
    add(OP_KEY,   7, mk(0, 7, 0, 0, 0, 0, 0, 0, 0));
    add(OP_NEXT,  0, mk(0, 7, 0, 0, 0, 0, 0, 0, 0));
    add(OP_DONE,  0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(OP_KEY,   7, mk(1, 7, 0, 0, 0, 0, 0, 0, 0));
    add(OP_NEXT,  0, mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
    add(OP_KEY,   1, mk(1, 1, 1, 0, 0, 0, 0, 0, 0));
    add(OP_NEXT,  0, mk(1, 0, 2, 0, 0, 0, 0, 0, 0));
    add(OP_KEY,   5, mk(1, 5, 2, 0, 0, 0, 0, 0, 0));
    add(OP_NEXT,  0, mk(1, 0, 3, 0, 0, 0, 0, 0, 0));
    add(OP_DONE,  0, mk(2, 0, 3, 0, 0, 0, 0, 0, 0));
    add(OP_KEY,   7, mk(2, 7, 3, 0, 0, 0, 0, 0, 0));
    add(OP_NEXT,  0, mk(2, 0, 3, 1, 1, 1, 1, 0, 0));
    add(OP_KEY,   2, mk(2, 2, 3, 1, 1, 1, 1, 0, 0));
    add(OP_NEXT,  0, mk(2, 0, 3, 2, 1, 1, 0, 0, 0));
    add(OP_KEY,   5, mk(2, 5, 3, 2, 1, 1, 0, 0, 0));
    add(OP_NEXT,  0, mk(2, 0, 3, 3, 2, 1, 1, 0, 0));
    add(OP_IDLE,  0, mk(3, 0, 3, 3, 2, 1, 1, 0, 0));
    add(OP_DONE,  0, z);
    // round 2: same message, all guesses correct
    add(OP_DONE,  0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(OP_KEY,   7, mk(1, 7, 0, 0, 0, 0, 0, 0, 0));
    add(OP_NEXT,  0, mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
    add(OP_KEY,   1, mk(1, 1, 1, 0, 0, 0, 0, 0, 0));
    add(OP_NEXT,  0, mk(1, 0, 2, 0, 0, 0, 0, 0, 0));
    add(OP_KEY,   5, mk(1, 5, 2, 0, 0, 0, 0, 0, 0));
    add(OP_NEXT,  0, mk(1, 0, 3, 0, 0, 0, 0, 0, 0));
    add(OP_DONE,  0, mk(2, 0, 3, 0, 0, 0, 0, 0, 0));
    add(OP_KEY,   7, mk(2, 7, 3, 0, 0, 0, 0, 0, 0));
    add(OP_NEXT,  0, mk(2, 0, 3, 1, 1, 1, 1, 0, 0));
    add(OP_KEY,   1, mk(2, 1, 3, 1, 1, 1, 1, 0, 0));
    add(OP_NEXT,  0, mk(2, 0, 3, 2, 2, 1, 1, 0, 0));
    add(OP_KEY,   5, mk(2, 5, 3, 2, 2, 1, 1, 0, 0));
    add(OP_NEXT,  0, mk(2, 0, 3, 3, 3, 1, 1, 0, 0));
    add(OP_IDLE,  0, mk(3, 0, 3, 3, 3, 1, 1, 1, 0));
    add(OP_DONE,  0, z);
    // tick+next stores the pre-shift symbol; done+next in GUESS drops the guess
    add(OP_DONE,  0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(OP_KEY,   3, mk(1, 3, 0, 0, 0, 0, 0, 0, 0));
    add(OP_TNEXT, 0, mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
    add(OP_KEY,   4, mk(1, 4, 1, 0, 0, 0, 0, 0, 0));
    add(OP_NEXT,  0, mk(1, 0, 2, 0, 0, 0, 0, 0, 0));
    add(OP_DONE,  0, mk(2, 0, 2, 0, 0, 0, 0, 0, 0));
    add(OP_KEY,   3, mk(2, 3, 2, 0, 0, 0, 0, 0, 0));
    add(OP_NEXT,  0, mk(2, 0, 2, 1, 1, 1, 1, 0, 0));
    add(OP_KEY,   6, mk(2, 6, 2, 1, 1, 1, 1, 0, 0));
    add(OP_DNEXT, 0, mk(3, 0, 2, 1, 1, 1, 1, 0, 0));
    add(OP_DONE,  0, z);
    // reset in GUESS with every other input asserted
    add(OP_DONE,  0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(OP_KEY,   1, mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    add(OP_NEXT,  0, mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
    add(OP_KEY,   1, mk(1, 1, 1, 0, 0, 0, 0, 0, 0));
    add(OP_NEXT,  0, mk(1, 0, 2, 0, 0, 0, 0, 0, 0));
    add(OP_DONE,  0, mk(2, 0, 2, 0, 0, 0, 0, 0, 0));
    add(OP_KEY,   1, mk(2, 1, 2, 0, 0, 0, 0, 0, 0));
    add(OP_NEXT,  0, mk(2, 0, 2, 1, 1, 1, 1, 0, 0));
    add(OP_KEY,   5, mk(2, 5, 2, 1, 1, 1, 1, 0, 0));
    add(OP_RST,   0, z);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sb_q.push_back(z);
    check_sb("reset_a", 0);
    sb_q.push_back(z);
    check_sb("reset_b", 1);

    for (int i = 0; i < vecs.size(); i++) begin
      sb_q.push_back(vecs[i].e);
      apply_op(vecs[i].op, vecs[i].sym);
      check_sb($sformatf("vec%0d_op%0d", i, vecs[i].op), 0);
    end

    // DEPTH=4 instance: empty-record done is ignored, fifth commit is dropped
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sb_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    apply_op(OP_DONE, 0);
    check_sb("b_enter_rec", 1);
    sb_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    apply_op(OP_DONE, 0);
    check_sb("b_done_empty", 1);
    for (int k = 1; k <= 5; k++) begin
      int rl;
      rl = (k > 4) ? 4 : k;
      apply_op(OP_KEY, k);
      sb_q.push_back(mk(1, (k == 5) ? k : 0, rl, 0, 0, 0, 0, 0, (k >= 4) ? 1 : 0));
      apply_op(OP_NEXT, 0);
      check_sb($sformatf("b_rec%0d", k), 1);
    end
    sb_q.push_back(mk(2, 0, 4, 0, 0, 0, 0, 0, 1));
    apply_op(OP_DONE, 0);
    check_sb("b_enter_guess", 1);
    for (int k = 1; k <= 4; k++) begin
      apply_op(OP_KEY, k);
      sb_q.push_back(mk(2, 0, 4, k, k, 1, 1, 0, 1));
      apply_op(OP_NEXT, 0);
      check_sb($sformatf("b_guess%0d", k), 1);
    end
    sb_q.push_back(mk(3, 0, 4, 4, 4, 1, 1, 1, 1));
    apply_op(OP_IDLE, 0);
    check_sb("b_result", 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/morse_match_engine.md
# morse_match_engine

Parametrised two-phase record/guess engine for the spy morse game: player 1 records a message of up to DEPTH morse symbols into internal storage, then player 2 keys guesses that are compared symbol-by-symbol against the stored message, and the block reports a score and a win flag. It runs on the board clock with a one-cycle `tick` enable instead of a derived slow clock. It absorbs the per-turn address pointers, symbol capture and RAM sequencing that the board top level performs, so the top level only maps keys, the 1 Hz tick and the displays.

## Interface
- SYM_W, 10: symbol width in bits, must be ≥ 2
- DEPTH, 16: maximum symbols per message, 1 ≤ DEPTH ≤ 2**ADDR_W
- ADDR_W, 4: storage address width; counters are ADDR_W+1 bits wide
- clock  in  1  board clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high
- tick  in  1  one-cycle sample enable, 1 Hz in the system
- key  in  1  morse key level, 1 = pressed, already inverted from KEY
- next  in  1  one-cycle pulse: commit current symbol
- done  in  1  one-cycle pulse: end current phase
- state  out  2  0 START, 1 REC, 2 GUESS, 3 RESULT
- sym_live  out  SYM_W  symbol being keyed
- rec_len  out  ADDR_W+1  symbols stored
- guess_idx  out  ADDR_W+1  guesses committed
- last_valid  out  1  last_match holds a real comparison
- last_match  out  1  result of the most recent guess
- score  out  ADDR_W+1  count of matching guesses
- win  out  1  high in RESULT iff score == rec_len
- mem_full  out  1  rec_len == DEPTH

## Operation
- Symbol capture: on `tick`, sym_live <= {sym_live[SYM_W-2:0], key}. It is cleared on reset, on every state change, and on every accepted `next`.
- `tick` and `next` in the same cycle: the pre-shift sym_live is committed, then cleared; that tick's shift is discarded.
- State transitions occur only on `done`; `tick` does not gate them:
  - START → REC: clears rec_len, guess_idx, score, last_valid, last_match.
  - REC → GUESS: only if rec_len > 0; otherwise `done` is ignored.
  - GUESS → RESULT.
  - RESULT → START.
- Automatic transition: GUESS → RESULT in the cycle after the guess that makes guess_idx == rec_len.
- REC, `next`:
  - If rec_len < DEPTH: mem[rec_len] <= sym_live, rec_len += 1.
  - If full: `next` is ignored and sym_live is not cleared.
- GUESS, `next`: last_match <= (sym_live == mem[guess_idx]); last_valid <= 1; score += match; guess_idx += 1.
- `next` is ignored in START and RESULT. `done` and `next` in the same cycle: `done` wins and `next` is dropped.
- Storage is a DEPTH × SYM_W register array, written synchronously and read combinationally at guess_idx. Contents persist across rounds but are only ever read below rec_len.
- score ≤ guess_idx ≤ rec_len ≤ DEPTH always; no counter wraps.

## Timing
- Reset values: state 0, sym_live 0, rec_len 0, guess_idx 0, score 0, last_valid 0, last_match 0, win 0, mem_full 0. Memory contents are undefined.
- Reset mid-round returns to START on the next edge; reset overrides done, next and tick.
- Latency:
  - `next` → updated rec_len/guess_idx/score/last_match: 1 cycle.
  - Final guess → state = RESULT: 2 cycles after the `next` edge.
  - `done` → state: 1 cycle.
- win and mem_full are combinational from registered state; win = (state == 3) && (score == rec_len).
- Pulses held longer than one cycle are acted on every cycle high; edge detection is upstream.

## Test plan
- Reset, then key = 1 for 3 ticks → sym_live = 0x007; `next` in START → no counter changes.
- START, `done` → REC. Record symbols 0x007, 0x001, 0x005 (one `next` after each) → rec_len = 3. `done` → GUESS.
- In GUESS, key 0x007, 0x002, 0x005 with a `next` after each:
  - last_match sequence is 1, 0, 1.
  - score = 2.
  - Auto RESULT with win = 0.
- Same round with all guesses correct → score = 3, win = 1. `done` → START and all counters cleared.
- DEPTH = 4: 5 `next`s in REC → rec_len = 4, mem_full = 1, and the fifth is ignored. `done` in REC with rec_len = 0 → state stays 1.
- Simultaneous events and reset:
  - `tick` + `next` same cycle → stored value is the pre-shift symbol.
  - `done` + `next` same cycle in GUESS → RESULT with guess_idx unchanged.
  - reset in GUESS → all outputs return to their reset values in 1 cycle.
